// File: rtl/head_tracker_if.sv
// Head tracker bus: direction/tick/restart inputs from the game control side
// and the registered head position and status outputs toward the body logic
// and pixel generator.
//   master : drives direction, pulse, sync; observes head_x/head_y/moved/wall_hit/running
//   slave  : the head tracker itself
interface head_tracker_if #(
    parameter int XW = 4,
    parameter int YW = 4
);
    logic [2:0]    direction;
    logic          pulse;
    logic          sync;
    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    logic          moved;
    logic          wall_hit;
    logic          running;

    modport master (
        output direction, pulse, sync,
        input  head_x, head_y, moved, wall_hit, running
    );

    modport slave (
        input  direction, pulse, sync,
        output head_x, head_y, moved, wall_hit, running
    );
endinterface

// File: rtl/head_tracker.sv
// Snake head tracker.
// Advances the head one grid cell per movement pulse in the commanded
// direction, stops on a wall crash and holds there until a restart (sync).
// Ports:
//   clk   : system clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : head_tracker_if slave -- direction/pulse/sync in;
//           head_x/head_y/moved/wall_hit/running out (all registered)
module head_tracker #(
    parameter int XW     = 4,
    parameter int YW     = 4,
    parameter int X_MAX  = 15,
    parameter int Y_MAX  = 11,
    parameter int X_INIT = 4,
    parameter int Y_INIT = 5
) (
    input  logic           clk,
    input  logic           nrst,
    head_tracker_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

    localparam logic [2:0] DIR_LEFT  = 3'd1;
    localparam logic [2:0] DIR_RIGHT = 3'd2;
    localparam logic [2:0] DIR_UP    = 3'd3;
    localparam logic [2:0] DIR_DOWN  = 3'd4;

    localparam logic [XW-1:0] XMAX_V  = XW'(X_MAX);
    localparam logic [YW-1:0] YMAX_V  = YW'(Y_MAX);
    localparam logic [XW-1:0] XINIT_V = XW'(X_INIT);
    localparam logic [YW-1:0] YINIT_V = YW'(Y_INIT);

    state_t        state_q, state_d;
    logic [XW-1:0] head_x_q, head_x_d;
    logic [YW-1:0] head_y_q, head_y_d;
    logic          moved_q, moved_d;
    logic          wall_hit_q, wall_hit_d;
    logic          running_q, running_d;

    // Candidate move for the sampled direction; go=0 for STOP and codes 5-7.
    logic          go;
    logic          hit;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;

    always_comb begin
        go  = 1'b1;
        hit = 1'b0;
        nx  = head_x_q;
        ny  = head_y_q;
        // Edge test on the current coordinate, so an underflow can never
        // masquerade as a legal cell.
        case (bus.direction)
            DIR_LEFT: begin
                hit = (head_x_q == '0);
                nx  = head_x_q - XW'(1);
            end
            DIR_RIGHT: begin
                hit = (head_x_q == XMAX_V);
                nx  = head_x_q + XW'(1);
            end
            DIR_UP: begin
                hit = (head_y_q == '0);
                ny  = head_y_q - YW'(1);
            end
            DIR_DOWN: begin
                hit = (head_y_q == YMAX_V);
                ny  = head_y_q + YW'(1);
            end
            default: go = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        head_x_d   = head_x_q;
        head_y_d   = head_y_q;
        moved_d    = 1'b0;
        wall_hit_d = wall_hit_q;

        if (bus.sync) begin
            // Restart wins over a coincident pulse.
            state_d    = IDLE;
            head_x_d   = XINIT_V;
            head_y_d   = YINIT_V;
            wall_hit_d = 1'b0;
        end else if (bus.pulse && go && state_q != CRASH) begin
            if (hit) begin
                state_d    = CRASH;
                wall_hit_d = 1'b1;
            end else begin
                state_d  = RUN;
                head_x_d = nx;
                head_y_d = ny;
                moved_d  = 1'b1;
            end
        end

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            head_x_q   <= XINIT_V;
            head_y_q   <= YINIT_V;
            moved_q    <= 1'b0;
            wall_hit_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_x_q   <= head_x_d;
            head_y_q   <= head_y_d;
            moved_q    <= moved_d;
            wall_hit_q <= wall_hit_d;
            running_q  <= running_d;
        end
    end

    assign bus.head_x   = head_x_q;
    assign bus.head_y   = head_y_q;
    assign bus.moved    = moved_q;
    assign bus.wall_hit = wall_hit_q;
    assign bus.running  = running_q;
endmodule

// File: tb/tb_head_tracker.sv
// Directed bench for head_tracker. Each step pushes the expected post-edge
// outputs onto a scoreboard queue, drives the inputs, and pops/compares once
// the registered outputs have settled after the rising edge.
module tb_head_tracker;
    localparam logic [2:0] STOP  = 3'd0;
    localparam logic [2:0] LEFT  = 3'd1;
    localparam logic [2:0] RIGHT = 3'd2;
    localparam logic [2:0] UP    = 3'd3;
    localparam logic [2:0] DOWN  = 3'd4;

    logic clk = 1'b0;
    logic nrst;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        string tag;
        int    x;
        int    y;
        logic  m;
        logic  w;
        logic  r;
    } exp_t;

    exp_t sb[$];

    head_tracker_if #(.XW(4), .YW(4)) bus ();

    head_tracker #(
        .XW(4), .YW(4), .X_MAX(15), .Y_MAX(11), .X_INIT(4), .Y_INIT(5)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, expv);
        end
    endtask

    task automatic compare_all(input exp_t e);
        chk({e.tag, ".x"},    32'(bus.head_x),   32'(e.x));
        chk({e.tag, ".y"},    32'(bus.head_y),   32'(e.y));
        chk({e.tag, ".mv"},   32'(bus.moved),    32'(e.m));
        chk({e.tag, ".wall"}, 32'(bus.wall_hit), 32'(e.w));
        chk({e.tag, ".run"},  32'(bus.running),  32'(e.r));
    endtask

    // One clock of stimulus; expectation is what the outputs show after the edge.
    task automatic step(input string tag, input logic [2:0] d, input logic p, input logic s,
                        input int ex, input int ey, input logic em, input logic ew, input logic er);
        exp_t e;
        e.tag = tag; e.x = ex; e.y = ey; e.m = em; e.w = ew; e.r = er;
        sb.push_back(e);
        @(negedge clk);
        bus.direction = d;
        bus.pulse     = p;
        bus.sync      = s;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s got=empty_scoreboard want=entry", tag);
        end else begin
            compare_all(sb.pop_front());
        end
    endtask

    initial begin
        exp_t e;
        bus.direction = STOP;
        bus.pulse     = 1'b0;
        bus.sync      = 1'b0;
        nrst          = 1'b0;
        #12;
        e.tag = "reset"; e.x = 4; e.y = 5; e.m = 0; e.w = 0; e.r = 0;
        compare_all(e);
        @(negedge clk);
        nrst = 1'b1;

        // First move out of IDLE, then strobe drops.
        step("first_right", RIGHT, 1, 0, 5, 5, 1, 0, 1);
        step("idle_after",  RIGHT, 0, 0, 5, 5, 0, 0, 1);
        step("up1", UP, 1, 0, 5, 4, 1, 0, 1);
        step("up2", UP, 1, 0, 5, 3, 1, 0, 1);
        step("up3", UP, 1, 0, 5, 2, 1, 0, 1);
        step("dir_no_pulse", LEFT, 0, 0, 5, 2, 0, 0, 1);

        // STOP pulse in IDLE keeps IDLE.
        step("sync_a", STOP, 0, 1, 4, 5, 0, 0, 0);
        step("idle_stop", STOP, 1, 0, 4, 5, 0, 0, 0);

        // Left wall.
        for (int i = 3; i >= 0; i--) step("left_walk", LEFT, 1, 0, i, 5, 1, 0, 1);
        step("left_wall",   LEFT,  1, 0, 0, 5, 0, 1, 0);
        step("crash_right", RIGHT, 1, 0, 0, 5, 0, 1, 0);
        step("crash_hold",  STOP,  0, 0, 0, 5, 0, 1, 0);

        // Bottom wall, no wrap to 0.
        step("sync_b", STOP, 0, 1, 4, 5, 0, 0, 0);
        for (int i = 6; i <= 11; i++) step("down_walk", DOWN, 1, 0, 4, i, 1, 0, 1);
        step("bottom_wall", DOWN, 1, 0, 4, 11, 0, 1, 0);

        // Right wall, no wrap to 0.
        step("sync_c", STOP, 0, 1, 4, 5, 0, 0, 0);
        for (int i = 5; i <= 15; i++) step("right_walk", RIGHT, 1, 0, i, 5, 1, 0, 1);
        step("right_wall", RIGHT, 1, 0, 15, 5, 0, 1, 0);

        // Top wall, no wrap to 11/15.
        step("sync_d", STOP, 0, 1, 4, 5, 0, 0, 0);
        for (int i = 4; i >= 0; i--) step("up_walk", UP, 1, 0, 4, i, 1, 0, 1);
        step("top_wall", UP, 1, 0, 4, 0, 0, 1, 0);

        // Sync beats a coincident pulse from (7,3).
        step("sync_e", STOP, 0, 1, 4, 5, 0, 0, 0);
        for (int i = 5; i <= 7; i++) step("to73_x", RIGHT, 1, 0, i, 5, 1, 0, 1);
        step("to73_y1", UP, 1, 0, 7, 4, 1, 0, 1);
        step("to73_y2", UP, 1, 0, 7, 3, 1, 0, 1);
        step("sync_pulse", RIGHT, 1, 1, 4, 5, 0, 0, 0);
        step("after_sync", STOP,  0, 0, 4, 5, 0, 0, 0);

        // STOP and illegal codes do not move and keep RUN.
        step("run_again", RIGHT, 1, 0, 5, 5, 1, 0, 1);
        step("stop_pulse", STOP, 1, 0, 5, 5, 0, 0, 1);
        step("code6",      3'd6, 1, 0, 5, 5, 0, 0, 1);
        step("code7",      3'd7, 1, 0, 5, 5, 0, 0, 1);
        step("down_ok",    DOWN, 1, 0, 5, 6, 1, 0, 1);

        // Asynchronous reset between edges.
        @(negedge clk);
        bus.pulse = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        e.tag = "async_reset"; e.x = 4; e.y = 5; e.m = 0; e.w = 0; e.r = 0;
        compare_all(e);
        @(negedge clk);
        nrst = 1'b1;
        step("post_reset", LEFT, 1, 0, 3, 5, 1, 0, 1);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
